beam_comparator: RTL and testbench
==================================

BEAM_COMPARATOR -- requirements
Module: beam_comparator

Interface
REQ-001 Parameter WIDTH, default 15, beam-counter and position width in bits (8 vertical + 7 horizontal).
REQ-002 Parameter CHANNELS, default 2, number of independent compare channels.
REQ-003 main_clk  input  1  main clock; all state updates on rising edge.
REQ-004 main_rst  input  1  reset, synchronous, active-high.
REQ-005 DB  input  WIDTH  data bus, source for position/mask loads.
REQ-006 VV  input  WIDTH  beam-counter value.
REQ-007 C1  input  1  PHI1 strobe, one main_clk cycle wide; qualifies beam sampling.
REQ-008 LQ  input  CHANNELS  per-channel load-position strobe.
REQ-009 LM  input  CHANNELS  per-channel load-mask strobe.
REQ-010 EN  input  CHANNELS  per-channel arm level; gates HIT and STK.
REQ-011 CLR  input  CHANNELS  per-channel sticky-flag clear.
REQ-012 GE  output  CHANNELS  registered level: sampled beam >= masked position.
REQ-013 HIT  output  CHANNELS  one-cycle pulse on armed GE rising edge.
REQ-014 STK  output  CHANNELS  sticky hit flag.
REQ-015 EQ  output  CHANNELS  registered masked-equality level (see Configuration).

Function
REQ-016 LQ[i] high: Q[i] <= DB at the clock edge; LM[i] high: M[i] <= DB; both may fire the same cycle.
REQ-017 Mask bit M[i][b]=1 compares that bit; M[i][b]=0 excludes it (operand B bit = VV bit, so the bit always ties).
REQ-018 Stage 1, on C1: A <= VV; B[i] <= (Q[i] & M[i]) | (VV & ~M[i]); V1 <= 1; without C1, V1 <= 0, A/B hold.
REQ-019 LQ/LM coincident with C1: stage 1 uses the pre-load Q/M; the new value takes effect at the next C1.
REQ-020 Stage 2, when V1=1: GE[i] <= (A >= B[i]) unsigned over WIDTH bits; when V1=0, GE holds.
REQ-021 Latency: GE reflects the VV sampled at C1 two main_clk edges after the C1 cycle.
REQ-022 Comparison is an unsigned full-width borrow chain, LSB first, borrow-in 0; no signed or modular interpretation.
REQ-023 HIT[i] = 1 for exactly one cycle, the cycle after GE[i] goes 0->1 while EN[i]=1; otherwise 0.
REQ-024 STK[i] sets on the cycle HIT[i] is asserted; clears on CLR[i] or LQ[i]; set and clear in the same cycle: set wins.
REQ-025 Beam wrap-around (VV returns below position): GE falls; the next crossing re-asserts HIT.
REQ-026 EN[i] low: HIT[i] = 0 and STK[i] holds; GE[i] still tracks.
REQ-027 GE already 1 when EN rises: no HIT until GE falls and rises again.
REQ-028 Channels fully independent; one shared A register.

Reset
REQ-029 main_rst high at a rising edge: Q=0, M=all ones, A=0, B=0, V1=0, GE=0, HIT=0, STK=0, EQ=0.
REQ-030 Reset mid-pipeline discards any in-flight sample; the first GE update follows the first C1 after reset.
REQ-031 Reset has priority over all loads, strobes and clears in the same cycle.

Configuration
REQ-032 Macro BEAM_CMP_EQ_EN defined: EQ[i] <= (A == B[i]) on the same V1 qualifier and latency as GE.
REQ-033 Macro BEAM_CMP_EQ_EN undefined: EQ tied to 0, no equality logic built; all other behaviour identical.

Verification
REQ-034 Reset, then C1 with VV=0 -> GE=all ones two cycles later, HIT=0 (EN low), STK=0.
REQ-035 WIDTH=15, Q[0]=0x0100, M[0]=0x7FFF, EN[0]=1, C1 with VV 0x00FF then 0x0100 -> GE[0] 0 then 1, one HIT[0] pulse, STK[0]=1.
REQ-036 M[0]=0x7F00, Q[0]=0x0500, VV=0x0503 at C1 -> GE[0]=1; with BEAM_CMP_EQ_EN, EQ[0]=1.
REQ-037 STK[0]=1, CLR[0] asserted in the same cycle as a new HIT[0] -> STK[0]=1; CLR[0] alone next cycle -> STK[0]=0.
REQ-038 LQ[1] loads 0x0200 in the same cycle as C1 with VV=0x0150, old Q[1]=0x0100 -> GE[1]=1 from old Q; next C1 with same VV -> GE[1]=0.
REQ-039 GE[0]=1, VV wraps 0x7FFF -> 0x0000 -> 0x0100 -> GE[0] falls then rises, second HIT[0] pulse; main_rst between the C1 and the GE update -> GE stays 0.

Source files
------------

// File: rtl/beam_comparator.sv
// Beam-position comparator: per-channel masked position compare against a shared sampled beam counter.
// Optional masked-equality output EQ is built only when BEAM_CMP_EQ_EN is defined.
module beam_comparator #(
    parameter int unsigned WIDTH    = 15,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                main_clk,
    input  logic                main_rst,
    input  logic [WIDTH-1:0]    DB,
    input  logic [WIDTH-1:0]    VV,
    input  logic                C1,
    input  logic [CHANNELS-1:0] LQ,
    input  logic [CHANNELS-1:0] LM,
    input  logic [CHANNELS-1:0] EN,
    input  logic [CHANNELS-1:0] CLR,
    output logic [CHANNELS-1:0] GE,
    output logic [CHANNELS-1:0] HIT,
    output logic [CHANNELS-1:0] STK,
    output logic [CHANNELS-1:0] EQ
);

    logic [WIDTH-1:0]    q_r [CHANNELS];
    logic [WIDTH-1:0]    m_r [CHANNELS];
    logic [WIDTH-1:0]    b_r [CHANNELS];
    logic [WIDTH-1:0]    a_r;
    logic                v1_r;
    logic [CHANNELS-1:0] ge_prev;
    logic [CHANNELS-1:0] hit_c;
    logic [CHANNELS-1:0] ge_c;

    // Unsigned full-width compare: no borrow out of A - B means A >= B.
    always_comb begin
        ge_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            logic [WIDTH:0] diff;
            diff     = {1'b0, a_r} - {1'b0, b_r[i]};
            ge_c[i]  = ~diff[WIDTH];
        end
    end

    // Armed rising edge of GE, seen one cycle after GE rises.
    assign hit_c = EN & GE & ~ge_prev;

    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            a_r     <= '0;
            v1_r    <= 1'b0;
            GE      <= '0;
            ge_prev <= '0;
            HIT     <= '0;
            STK     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                q_r[i] <= '0;
                m_r[i] <= '1;
                b_r[i] <= '0;
            end
        end else begin
            v1_r    <= C1;
            ge_prev <= GE;
            HIT     <= hit_c;
            if (C1) begin
                a_r <= VV;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                // Stage 1 uses pre-load Q/M; masked-out bits take the beam bit so they always tie.
                if (C1) begin
                    b_r[i] <= (q_r[i] & m_r[i]) | (VV & ~m_r[i]);
                end
                if (LQ[i]) begin
                    q_r[i] <= DB;
                end
                if (LM[i]) begin
                    m_r[i] <= DB;
                end
                if (v1_r) begin
                    GE[i] <= ge_c[i];
                end
                if (hit_c[i]) begin
                    STK[i] <= 1'b1;
                end else if (CLR[i] || LQ[i]) begin
                    STK[i] <= 1'b0;
                end
            end
        end
    end

`ifdef BEAM_CMP_EQ_EN
    always_ff @(posedge main_clk) begin
        if (main_rst) begin
            EQ <= '0;
        end else if (v1_r) begin
            for (int i = 0; i < CHANNELS; i++) begin
                EQ[i] <= (a_r == b_r[i]);
            end
        end
    end
`else
    assign EQ = '0;
`endif

endmodule

// File: tb/tb_beam_comparator.sv
// Self-checking bench for beam_comparator: directed scenarios then randomized traffic vs a reference model.
module tb_beam_comparator;

    localparam int unsigned WIDTH    = 15;
    localparam int unsigned CHANNELS = 2;

    logic                main_clk = 1'b0;
    logic                main_rst;
    logic [WIDTH-1:0]    DB, VV;
    logic                C1;
    logic [CHANNELS-1:0] LQ, LM, EN, CLR;
    logic [CHANNELS-1:0] GE, HIT, STK, EQ;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0]    mq [CHANNELS];
    logic [WIDTH-1:0]    mm [CHANNELS];
    logic                pend_valid;
    logic [WIDTH-1:0]    pend_vv;
    logic [WIDTH-1:0]    pend_q [CHANNELS];
    logic [WIDTH-1:0]    pend_m [CHANNELS];
    logic [CHANNELS-1:0] e_ge, e_ge_last, e_hit, e_stk, e_eq;

    beam_comparator #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .DB       (DB),
        .VV       (VV),
        .C1       (C1),
        .LQ       (LQ),
        .LM       (LM),
        .EN       (EN),
        .CLR      (CLR),
        .GE       (GE),
        .HIT      (HIT),
        .STK      (STK),
        .EQ       (EQ)
    );

    initial forever #5 main_clk = ~main_clk;

    task automatic check(input string tag, input logic [CHANNELS-1:0] obs, input logic [CHANNELS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Model: unmasked bits always tie, so the compare reduces to the masked beam against the masked position.
    task automatic model_edge();
        logic [CHANNELS-1:0] rose;
        if (main_rst) begin
            pend_valid = 1'b0;
            pend_vv    = '0;
            e_ge = '0; e_ge_last = '0; e_hit = '0; e_stk = '0; e_eq = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mq[i] = '0;
                mm[i] = '1;
            end
        end else begin
            rose      = EN & e_ge & ~e_ge_last;
            e_ge_last = e_ge;
            if (pend_valid) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    e_ge[i] = (pend_vv & pend_m[i]) >= (pend_q[i] & pend_m[i]);
`ifdef BEAM_CMP_EQ_EN
                    e_eq[i] = (pend_vv & pend_m[i]) == (pend_q[i] & pend_m[i]);
`endif
                end
            end
            e_hit = rose;
            for (int i = 0; i < CHANNELS; i++) begin
                if (rose[i]) e_stk[i] = 1'b1;
                else if (CLR[i] || LQ[i]) e_stk[i] = 1'b0;
            end
            pend_valid = C1;
            if (C1) begin
                pend_vv = VV;
                for (int i = 0; i < CHANNELS; i++) begin
                    pend_q[i] = mq[i];
                    pend_m[i] = mm[i];
                end
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (LQ[i]) mq[i] = DB;
                if (LM[i]) mm[i] = DB;
            end
        end
    endtask

    // One clock: inputs already driven; update model at the edge, check 1 time unit later, then idle strobes.
    task automatic tick();
        @(posedge main_clk);
        model_edge();
        #1;
        check("ge",  GE,  e_ge);
        check("hit", HIT, e_hit);
        check("stk", STK, e_stk);
        check("eq",  EQ,  e_eq);
        main_rst = 1'b0; C1 = 1'b0; LQ = '0; LM = '0; CLR = '0;
    endtask

    task automatic sample(input logic [WIDTH-1:0] v);
        C1 = 1'b1; VV = v;
        tick();
        tick();
    endtask

    task automatic load(input logic [CHANNELS-1:0] lq, input logic [CHANNELS-1:0] lm, input logic [WIDTH-1:0] d);
        LQ = lq; LM = lm; DB = d;
        tick();
    endtask

    initial begin
        main_rst = 1'b1; DB = '0; VV = '0; C1 = 1'b0;
        LQ = '0; LM = '0; EN = '0; CLR = '0;
        tick();
        main_rst = 1'b1;
        tick();
        check("rst_ge", GE, '0);
        check("rst_stk", STK, '0);

        // Reset state compares everything as >= 0
        sample(15'h0000);
        check("req034_ge", GE, 2'b11);
        check("req034_hit", HIT, 2'b00);

        // Basic crossing on channel 0
        load(2'b01, 2'b00, 15'h0100);
        load(2'b00, 2'b01, 15'h7FFF);
        EN = 2'b01;
        sample(15'h00FF);
        check("req035_ge_lo", GE & 2'b01, 2'b00);
        sample(15'h0100);
        check("req035_ge_hi", GE & 2'b01, 2'b01);
        tick();
        check("req035_hit", HIT & 2'b01, 2'b01);
        check("req035_stk", STK & 2'b01, 2'b01);
        tick();
        check("req035_hit_once", HIT & 2'b01, 2'b00);

        // Sticky set beats clear in the same cycle, clear alone then clears
        sample(15'h00FF);
        sample(15'h0100);
        CLR = 2'b01;
        tick();
        check("req037_hit", HIT & 2'b01, 2'b01);
        check("req037_stk_set", STK & 2'b01, 2'b01);
        CLR = 2'b01;
        tick();
        check("req037_stk_clr", STK & 2'b01, 2'b00);

        // Masked compare with don't-care low bits
        load(2'b00, 2'b01, 15'h7F00);
        load(2'b01, 2'b00, 15'h0500);
        sample(15'h0503);
        check("req036_ge", GE & 2'b01, 2'b01);
`ifdef BEAM_CMP_EQ_EN
        check("req036_eq", EQ & 2'b01, 2'b01);
`endif

        // Load coincident with C1 uses old position
        load(2'b10, 2'b00, 15'h0100);
        LQ = 2'b10; DB = 15'h0200; C1 = 1'b1; VV = 15'h0150;
        tick();
        tick();
        check("req038_old_q", GE & 2'b10, 2'b10);
        sample(15'h0150);
        check("req038_new_q", GE & 2'b10, 2'b00);

        // Beam wrap-around re-arms HIT; reset mid-pipeline discards the sample
        load(2'b01, 2'b01, 15'h7FFF);
        load(2'b01, 2'b00, 15'h0100);
        sample(15'h7FFF);
        sample(15'h0000);
        check("req039_fall", GE & 2'b01, 2'b00);
        sample(15'h0100);
        check("req039_rise", GE & 2'b01, 2'b01);
        tick();
        check("req039_hit2", HIT & 2'b01, 2'b01);
        sample(15'h0000);
        C1 = 1'b1; VV = 15'h0100;
        tick();
        main_rst = 1'b1;
        tick();
        tick();
        check("req039_rst_ge", GE, 2'b00);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            main_rst = ($urandom_range(63) == 0);
            C1  = 1'(($urandom_range(2) == 0));
            VV  = WIDTH'($urandom);
            DB  = ($urandom_range(3) == 0) ? 15'h7FFF : WIDTH'($urandom);
            LQ  = CHANNELS'($urandom) & CHANNELS'($urandom) & CHANNELS'($urandom);
            LM  = CHANNELS'($urandom) & CHANNELS'($urandom) & CHANNELS'($urandom);
            CLR = CHANNELS'($urandom) & CHANNELS'($urandom);
            if ($urandom_range(15) == 0) EN = CHANNELS'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
